antilog: RTL and testbench
==========================

Name: antilog

Overview:
- Inverse of the log2 approximator: takes an 8-bit log-domain code and returns its linear value 2^x.
- Input code: bits [7:5] = integer exponent e, bits [4:0] = fraction f in Q0.5.
- Computes mantissa 2^(f/32) iteratively, one fraction bit per cycle, using a 5-entry constant table. It then shifts by e.
- Sits downstream of the log block, closing the log/antilog datapath. Uses a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 8: width of log code and linear result. Only 8 is supported (3-bit exponent / 5-bit fraction split is fixed).
- MANT_FRAC, 8: fractional bits of the internal mantissa register m (Q1.MANT_FRAC).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- log_i  in  DATA_WIDTH  log-domain code {e[2:0], f[4:0]}
- valid_i  in  1  log_i valid
- ready_o  out  1  block can accept a code
- number_o  out  DATA_WIDTH  linear result
- valid_o  out  1  number_o valid
- ready_i  in  1  downstream accepts number_o

Behaviour:
- Reset (async, rst_i=1): state=IDLE, ready_o=0 while rst_i high and 1 from the first cycle after release. valid_o=0, number_o=0, m=0, step counter k=0, e/f registers=0.
- Reset mid-operation aborts the computation immediately. No output is produced for the aborted code.
- States: IDLE, CALC, OUT, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: latch e=log_i[7:5] and f=log_i[4:0], load m=2^MANT_FRAC (256 = 1.0), k=0, go to CALC.
- CALC (exactly 5 cycles, fixed, independent of f):
  - Step k tests bit f[4-k].
  - If the bit is set: m <= (m*K[k]) >> MANT_FRAC, truncating. Otherwise m holds.
  - k increments. After k=4, go to OUT.
- Constant table K, Q1.8, round-to-nearest:
  - K[0]=362 (2^(1/2))
  - K[1]=304 (2^(1/4))
  - K[2]=279 (2^(1/8))
  - K[3]=267 (2^(1/16))
  - K[4]=262 (2^(1/32))
- Width rules:
  - m is 9 bits; maximum reachable value is 498.
  - The product needs 18 bits.
- OUT (1 cycle): number_o <= (m << e) >> MANT_FRAC, truncating, computed in 16 bits. Max result 249, so no overflow. valid_o <= 1. Go to DONE.
- DONE:
  - valid_o=1 and number_o held stable.
  - On ready_i=1: valid_o <= 0, go to IDLE.
  - ready_o stays 0 until the state is IDLE, so a new code cannot be accepted in the same cycle the result is consumed.
- Latency: valid_o is first seen high 7 rising edges after the accepting edge (1 load + 5 CALC + 1 OUT). Throughput is one code per 8 cycles minimum with ready_i held high.
- Backpressure:
  - ready_i low in DONE stalls indefinitely with number_o stable.
  - valid_i and log_i are ignored outside IDLE.
- number_o keeps its last value after the handshake until the next OUT state.
- No X on any output at any time after reset.

Test Plan:
- Reset: assert rst_i mid-CALC -> valid_o=0, number_o=0 immediately (async). After release, ready_o=1 and the next code computes correctly.
- log_i=0x00 (e=0, f=0) -> number_o=1, valid_o seen high 7 edges after accept.
- log_i=0xA0 (e=5, f=0) -> number_o=32. log_i=0xE0 -> number_o=128.
- log_i=0x70 (e=3, f=16) -> m=362 after CALC, number_o=11.
- log_i=0xFF (e=7, f=31):
  - m sequence 362, 429, 467, 487, 498 -> number_o=249.
- Backpressure and back-to-back:
  - Hold ready_i=0 for 10 cycles in DONE -> number_o/valid_o stable, ready_o=0, valid_i pulses ignored.
  - Release -> IDLE next cycle, queued code accepted; results in order.
  - Sweep all 256 codes against a bench model of the same truncating algorithm.

Source files
------------

// File: rtl/antilog_if.sv
// Handshake bundle for the antilog block: log code in, linear result out.
interface antilog_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] log_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] number_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  log_i,
    input  valid_i,
    output ready_o,
    output number_o,
    output valid_o,
    input  ready_i
  );

  modport master (
    output log_i,
    output valid_i,
    input  ready_o,
    input  number_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/antilog.sv
// Log-domain to linear converter: 2^(e + f/32) via a 5-step multiplicative
// mantissa refinement followed by a shift by the integer exponent.
//
// state | meaning
// IDLE  | ready_o high, waiting for a log code
// CALC  | five fixed steps, one fraction bit per cycle
// OUT   | shift mantissa by exponent, register the result
// DONE  | result presented, waiting for ready_i
module antilog #(
  parameter int DATA_WIDTH = 8,
  parameter int MANT_FRAC  = 8
) (
  input logic       clk_i,
  input logic       rst_i,
  antilog_if.slave  bus
);

  localparam int MW = MANT_FRAC + 1;
  localparam int PW = 2 * MW;
  localparam int SW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2:0]            e_q;
  logic [4:0]            f_q;
  logic [MW-1:0]         m_q;
  logic [2:0]            k_q;
  logic [DATA_WIDTH-1:0] number_q;
  logic                  valid_q;

  logic                  accept;
  logic                  f_bit;
  logic [MW-1:0]         k_const;
  logic [PW-1:0]         product;
  logic [MW-1:0]         m_step;
  logic [SW-1:0]         shifted;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.valid_i) state_d = CALC;
      CALC: if (k_q == 3'd4) state_d = OUT;
      OUT:  state_d = DONE;
      DONE: if (bus.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; ready is held low while reset is asserted
  always_comb begin
    bus.ready_o  = (state_q == IDLE) && !rst_i;
    bus.valid_o  = valid_q;
    bus.number_o = number_q;
  end

  assign accept = (state_q == IDLE) && bus.valid_i;

  // Step k examines fraction bits MSB first with the matching 2^(1/2^(k+1)) factor
  always_comb begin
    f_bit   = 1'b0;
    k_const = MW'(256);
    case (k_q)
      3'd0: begin f_bit = f_q[4]; k_const = MW'(362); end
      3'd1: begin f_bit = f_q[3]; k_const = MW'(304); end
      3'd2: begin f_bit = f_q[2]; k_const = MW'(279); end
      3'd3: begin f_bit = f_q[1]; k_const = MW'(267); end
      3'd4: begin f_bit = f_q[0]; k_const = MW'(262); end
      default: begin f_bit = 1'b0; k_const = MW'(256); end
    endcase
  end

  assign product = {{MW{1'b0}}, m_q} * {{MW{1'b0}}, k_const};
  assign m_step  = product[MANT_FRAC +: MW];
  assign shifted = {{(SW-MW){1'b0}}, m_q} << e_q;

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_q      <= '0;
      f_q      <= '0;
      m_q      <= '0;
      k_q      <= '0;
      number_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            e_q <= bus.log_i[7:5];
            f_q <= bus.log_i[4:0];
            m_q <= MW'(1 << MANT_FRAC);
            k_q <= '0;
          end
        end
        CALC: begin
          if (f_bit) m_q <= m_step;
          k_q <= k_q + 3'd1;
        end
        OUT: begin
          number_q <= shifted[MANT_FRAC +: DATA_WIDTH];
          valid_q  <= 1'b1;
        end
        DONE: begin
          if (bus.ready_i) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_antilog.sv
// Randomized bench for antilog: scoreboard fed by a plain-arithmetic model,
// plus directed literal results, backpressure and mid-calculation reset.
module tb_antilog;

  logic clk = 1'b0;
  logic rst = 1'b1;

  antilog_if #(.DATA_WIDTH(8)) bus ();

  antilog #(.DATA_WIDTH(8), .MANT_FRAC(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_ready = 1'b0;

  int exp_q[$];
  int acc_q[$];
  bit prev_valid = 1'b0;
  bit prev_ready = 1'b0;
  int prev_num = 0;

  function automatic int model(input logic [7:0] code);
    int kt[5] = '{362, 304, 279, 267, 262};
    int e = int'(code[7:5]);
    int f = int'(code[4:0]);
    int m = 256;
    for (int i = 0; i < 5; i++)
      if ((f & (16 >> i)) != 0) m = (m * kt[i]) / 256;
    return (m * (1 << e)) / 256;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rnd_ready) begin
    #1 bus.ready_i = ($urandom % 4) != 0;
  end

  // Compare process: checks outputs every cycle against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      chk("no_x", int'($isunknown({bus.ready_o, bus.valid_o, bus.number_o})), 0);
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", int'(bus.valid_o), 1);
        chk("stall_number", int'(bus.number_o), prev_num);
      end
      if (bus.valid_o) begin
        chk("ready_low_in_done", int'(bus.ready_o), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("number", int'(bus.number_o), exp_q[0]);
          if (!prev_valid) chk("latency", cyc - acc_q[0], 7);
          if (bus.ready_i) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      if (bus.valid_i && bus.ready_o) begin
        exp_q.push_back(model(bus.log_i));
        acc_q.push_back(cyc);
      end
      prev_valid = bus.valid_o;
      prev_ready = bus.ready_i;
      prev_num   = int'(bus.number_o);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [7:0] code);
    int n = 0;
    bus.log_i   = code;
    bus.valid_i = 1'b1;
    @(negedge clk);
    while (!bus.ready_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
  endtask

  task automatic run_one(input logic [7:0] code, input int exp);
    int n = 0;
    send(code);
    @(negedge clk);
    while (!bus.valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("direct_%02h", code), int'(bus.number_o), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int held;
    bus.log_i   = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;

    chk("model_00", model(8'h00), 1);
    chk("model_A0", model(8'hA0), 32);
    chk("model_70", model(8'h70), 11);
    chk("model_FF", model(8'hFF), 249);

    #12;
    chk("rst_ready", int'(bus.ready_o), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_number", int'(bus.number_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(bus.ready_o), 1);
    @(posedge clk);
    #1;

    run_one(8'h00, 1);
    run_one(8'hA0, 32);
    run_one(8'hE0, 128);
    run_one(8'h70, 11);
    run_one(8'hFF, 249);

    // Backpressure: stall in DONE with stray valid_i pulses
    bus.ready_i = 1'b0;
    send(8'h5B);
    n = 0;
    while (!bus.valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_seen", int'(bus.valid_o), 1);
    held = int'(bus.number_o);
    for (int i = 0; i < 10; i++) begin
      bus.valid_i = ($urandom % 2) != 0;
      bus.log_i   = 8'($urandom);
      @(negedge clk);
      chk("bp_ready_low", int'(bus.ready_o), 0);
      chk("bp_held", int'(bus.number_o), held);
      @(posedge clk);
      #1;
    end
    bus.ready_i = 1'b1;
    send(8'h3C);
    send(8'h9F);
    repeat (10) @(posedge clk);
    #1;

    // Asynchronous reset while in CALC
    send(8'h77);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.valid_o), 0);
    chk("arst_number", int'(bus.number_o), 0);
    chk("arst_ready", int'(bus.ready_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_ready_after", int'(bus.ready_o), 1);
    @(posedge clk);
    #1;
    run_one(8'hFF, 249);

    // Sweep all codes with random downstream backpressure and gaps
    rnd_ready = 1'b1;
    for (int c = 0; c < 256; c++) begin
      send(8'(c));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 bus.ready_i = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.valid_o) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
